way_priority_scheduler: RTL and testbench

WAY_PRIORITY_SCHEDULER -- requirements
Module: way_priority_scheduler

---
 rtl/way_priority_scheduler.sv | 154 +++++++++++++++
 tb/tb_way_priority_scheduler.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/way_priority_scheduler.sv
// way_priority_scheduler
//   Picks one of NUM_WAY requesting ways and presents it to the downstream
//   consumer with a valid/ready handshake. Each way carries a priority, and
//   the scheduler grants the eligible way with the highest score. Ties go to
//   the lowest way index.
//
//   Optional feature macro: SCHEDULER_AGING_EN
//     defined   : score = priority + per-way age. The age counts the cycles a
//                 way has waited, so low-priority ways cannot starve.
//     undefined : score = priority. There are no age counters.
//
// Ports
//   clk_in              : the single clock
//   reset_in            : synchronous active-high reset
//   request_in          : per-way request, held high until granted
//   priority_flatted_in : per-way priority, way i at [i*W +: W]
//   issue_ready_in      : downstream accepts the presented grant
//   issue_valid_out     : a grant is presented
//   issue_way_out       : index of the granted way
//   issue_onehot_out    : one-hot form of issue_way_out, zero when not valid
module way_priority_scheduler #(
  parameter int SINGLE_WAY_WIDTH_IN_BITS = 4,
  parameter int NUM_WAY                  = 16,
  parameter int NUM_WAY_INDEX_WIDTH      = 4
) (
  input  logic                                         clk_in,
  input  logic                                         reset_in,
  input  logic [NUM_WAY-1:0]                           request_in,
  input  logic [SINGLE_WAY_WIDTH_IN_BITS*NUM_WAY-1:0]  priority_flatted_in,
  input  logic                                         issue_ready_in,
  output logic                                         issue_valid_out,
  output logic [NUM_WAY_INDEX_WIDTH-1:0]               issue_way_out,
  output logic [NUM_WAY-1:0]                           issue_onehot_out
);

  localparam int W  = SINGLE_WAY_WIDTH_IN_BITS;
  localparam int SW = W + 1;

  typedef enum logic {ST_IDLE, ST_HOLD} state_t;

  state_t                         r_state;
  logic                           r_valid;
  logic [NUM_WAY_INDEX_WIDTH-1:0] r_way;
  logic [NUM_WAY-1:0]             r_onehot;

  logic [NUM_WAY-1:0]             w_retire;
  logic [NUM_WAY-1:0]             w_eligible;
  logic [NUM_WAY-1:0]             w_sel_onehot;
  logic [SW-1:0]                  w_score [NUM_WAY];
  logic [SW-1:0]                  w_best;
  logic [NUM_WAY_INDEX_WIDTH-1:0] w_sel_idx;
  logic                           w_found;
  logic                           w_load;

  // The way completing its handshake this cycle is masked. Its request line
  // may still be high, and it must not be presented a second time.
  assign w_retire   = r_onehot & {NUM_WAY{r_valid & issue_ready_in}};
  assign w_eligible = request_in & ~w_retire;

  // A new grant is loaded from IDLE, or on a handshake so that there is no bubble.
  assign w_load = w_found & ((r_state == ST_IDLE) | issue_ready_in);

  genvar gi;

`ifdef SCHEDULER_AGING_EN
  generate
    for (gi = 0; gi < NUM_WAY; gi++) begin : g_age
      logic [W-1:0] r_age;

      always_ff @(posedge clk_in) begin
        if (reset_in || !request_in[gi] || (w_load && w_sel_onehot[gi])) begin
          r_age <= '0;
        end else if (r_age != {W{1'b1}}) begin
          r_age <= r_age + {{(W-1){1'b0}}, 1'b1};
        end
      end

      // The score is one bit wider than priority and age, so the sum cannot overflow.
      assign w_score[gi] = {1'b0, priority_flatted_in[gi*W +: W]} + {1'b0, r_age};
    end
  endgenerate
`else
  generate
    for (gi = 0; gi < NUM_WAY; gi++) begin : g_score
      assign w_score[gi] = {1'b0, priority_flatted_in[gi*W +: W]};
    end
  endgenerate
`endif

  // The strict '>' keeps the earlier (lower-index) way on a tie.
  always_comb begin
    w_best    = '0;
    w_sel_idx = '0;
    w_found   = 1'b0;
    for (int i = 0; i < NUM_WAY; i++) begin
      if (w_eligible[i] && (!w_found || (w_score[i] > w_best))) begin
        w_found   = 1'b1;
        w_best    = w_score[i];
        w_sel_idx = NUM_WAY_INDEX_WIDTH'(i);
      end
    end
  end

  generate
    for (gi = 0; gi < NUM_WAY; gi++) begin : g_sel_onehot
      assign w_sel_onehot[gi] = (w_sel_idx == NUM_WAY_INDEX_WIDTH'(gi));
    end
  endgenerate

  always_ff @(posedge clk_in) begin
    if (reset_in) begin
      r_state  <= ST_IDLE;
      r_valid  <= 1'b0;
      r_way    <= '0;
      r_onehot <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_found) begin
            r_state  <= ST_HOLD;
            r_valid  <= 1'b1;
            r_way    <= w_sel_idx;
            r_onehot <= w_sel_onehot;
          end
        end
        ST_HOLD: begin
          // Without ready the grant is frozen, whatever else arrives.
          if (issue_ready_in) begin
            if (w_load) begin
              r_way    <= w_sel_idx;
              r_onehot <= w_sel_onehot;
            end else begin
              r_state  <= ST_IDLE;
              r_valid  <= 1'b0;
              r_way    <= '0;
              r_onehot <= '0;
            end
          end
        end
        default: begin
          r_state  <= ST_IDLE;
          r_valid  <= 1'b0;
          r_way    <= '0;
          r_onehot <= '0;
        end
      endcase
    end
  end

  assign issue_valid_out  = r_valid;
  assign issue_way_out    = r_way;
  assign issue_onehot_out = r_onehot;

endmodule

// File: tb/tb_way_priority_scheduler.sv
// Testbench for way_priority_scheduler (W=4, NUM_WAY=16).
// A behavioural reference model tracks the expected grant and the ages.
// One compare process checks the outputs on every falling edge.
// The directed scenarios add literal expectations on top of the model.
module tb_way_priority_scheduler;

  localparam int W = 4;
  localparam int N = 16;
`ifdef SCHEDULER_AGING_EN
  localparam bit AGING = 1'b1;
`else
  localparam bit AGING = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic [N-1:0]  req;
  logic [W*N-1:0] prio;
  logic          ready;
  logic          valid;
  logic [3:0]    way;
  logic [N-1:0]  onehot;

  int n_checks = 0;
  int n_pass   = 0;
  bit chk_en   = 1'b0;

  always #5 clk = ~clk;

  way_priority_scheduler #(
    .SINGLE_WAY_WIDTH_IN_BITS(W),
    .NUM_WAY(N),
    .NUM_WAY_INDEX_WIDTH(4)
  ) dut (
    .clk_in(clk),
    .reset_in(rst),
    .request_in(req),
    .priority_flatted_in(prio),
    .issue_ready_in(ready),
    .issue_valid_out(valid),
    .issue_way_out(way),
    .issue_onehot_out(onehot)
  );

  // ---------------- reference model ----------------
  bit m_valid = 1'b0;
  int m_way   = 0;
  int m_age [N];

  always @(posedge clk) begin : model
    int  best;
    int  bscore;
    int  s;
    bit  retire;
    bit  load;
    if (rst) begin
      m_valid <= 1'b0;
      m_way   <= 0;
      for (int i = 0; i < N; i++) m_age[i] <= 0;
    end else begin
      best   = -1;
      bscore = -1;
      retire = m_valid && ready;
      for (int i = 0; i < N; i++) begin
        if (req[i] && !(retire && i == m_way)) begin
          s = int'(prio[i*W +: W]) + (AGING ? m_age[i] : 0);
          if (s > bscore) begin
            bscore = s;
            best   = i;
          end
        end
      end
      load = (best >= 0) && (!m_valid || ready);
      if (load) begin
        m_valid <= 1'b1;
        m_way   <= best;
      end else if (m_valid && ready) begin
        m_valid <= 1'b0;
      end
      for (int i = 0; i < N; i++) begin
        if (!req[i] || (load && i == best)) m_age[i] <= 0;
        else m_age[i] <= (m_age[i] < 15) ? m_age[i] + 1 : 15;
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    else n_pass++;
  endtask

  // ---------------- compare process ----------------
  always @(negedge clk) begin
    if (chk_en) begin
      chk("valid", 32'(valid), 32'(m_valid));
      if (m_valid) begin
        chk("way", 32'(way), 32'(m_way));
        chk("onehot", 32'(onehot), 32'(1) << m_way);
        if (ready && !rst) $display("grant way %0d accepted at %0t", m_way, $time);
      end else begin
        chk("onehot_idle", 32'(onehot), 32'd0);
      end
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic set_prio(input int w_idx, input int p);
    logic [3:0] v;
    v = 4'(p);
    prio[w_idx*W +: W] = v;
  endtask

  bit seen4;

  initial begin
    rst   = 1'b1;
    req   = 16'hffff;
    prio  = '0;
    ready = 1'b0;

    // Reset is held for two cycles with every way requesting.
    tick();
    chk_en = 1'b1;
    tick();
    chk("reset_valid", 32'(valid), 32'd0);
    chk("reset_way", 32'(way), 32'd0);
    chk("reset_onehot", 32'(onehot), 32'd0);
    rst   = 1'b0;
    ready = 1'b1;
    tick();
    chk("first_valid", 32'(valid), 32'd1);
    chk("first_way", 32'(way), 32'd0);
    req = '0;
    tick();
    tick();

    // A single request from way 5.
    set_prio(5, 3);
    req = 16'h0020;
    tick();
    chk("w5_valid", 32'(valid), 32'd1);
    chk("w5_way", 32'(way), 32'd5);
    chk("w5_onehot", 32'(onehot), 32'h0020);
    req = '0;
    tick();
    chk("w5_idle", 32'(valid), 32'd0);

    // Way 9 outranks way 2. The two are granted back to back, then the scheduler goes idle.
    set_prio(2, 10);
    set_prio(9, 12);
    req = 16'h0204;
    tick();
    chk("w9_first", 32'(way), 32'd9);
    req[9] = 1'b0;
    tick();
    chk("w2_next", 32'(way), 32'd2);
    chk("w2_valid", 32'(valid), 32'd1);
    req[2] = 1'b0;
    tick();
    chk("after_w2_idle", 32'(valid), 32'd0);

    // Ways 3 and 7 tie on priority, so the lower index wins.
    set_prio(3, 6);
    set_prio(7, 6);
    req = 16'h0088;
    tick();
    chk("tie_low_idx", 32'(way), 32'd3);
    req[3] = 1'b0;
    tick();
    chk("tie_second", 32'(way), 32'd7);
    req = '0;
    tick();
    tick();

    // The grant stays on way 4 while ready is low, even though way 0 outranks it.
    ready = 1'b0;
    set_prio(4, 1);
    req = 16'h0010;
    tick();
    chk("hold_w4", 32'(way), 32'd4);
    set_prio(0, 15);
    req[0] = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tick();
      chk("hold_stable", 32'(way), 32'd4);
    end
    ready = 1'b1;
    tick();
    chk("hold_then_w0", 32'(way), 32'd0);
    req = '0;
    tick();
    tick();

    // Starvation test: ways 1 and 3 request at priority f, way 4 at priority 2.
    prio = '0;
    set_prio(1, 15);
    set_prio(3, 15);
    set_prio(4, 2);
    req   = 16'h001a;
    seen4 = 1'b0;
    for (int c = 0; c < 32; c++) begin
      tick();
      if (valid && way == 4'd4) seen4 = 1'b1;
    end
    chk("starvation", 32'(seen4), 32'(AGING));
    req = '0;
    tick();
    tick();

    // Random traffic, with an occasional reset in the middle of a hold.
    for (int c = 0; c < 600; c++) begin
      rst   = ($urandom_range(0, 79) == 0);
      req   = 16'($urandom) & 16'($urandom);
      ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 7) == 0) prio = {$urandom, $urandom};
      tick();
    end
    rst = 1'b0;
    req = '0;
    tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
